// File: rtl/button_conditioner_if.sv
// Pushbutton conditioning bus: raw button inputs in, debounced level and event pulses out.
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] button_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_hold;

  modport master (
    output button_raw,
    input  btn_level, btn_press, btn_release, btn_hold
  );

  modport slave (
    input  button_raw,
    output btn_level, btn_press, btn_release, btn_hold
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debounce filter, level/press/release outputs and a
// one-shot long-hold pulse; every channel is an independent copy.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic          s1_q, s2_q;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          hold_q, hold_d;

    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      hold_d    = 1'b0;
      case (state_q)
        RELEASED: begin
          level_d = 1'b0;
          if (s2_q) begin
            dcnt_d  = DW'(1);
            state_d = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q) begin
            dcnt_d  = '0;
            state_d = RELEASED;
          end else if (dcnt_q >= DMAX) begin
            level_d = 1'b1;
            press_d = 1'b1;
            dcnt_d  = '0;
            hcnt_d  = '0;
            state_d = PRESSED;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        PRESSED, RELEASE_WAIT: begin
          // The hold timer runs through a pending release so a bounce does not
          // restart or re-arm the long-hold pulse.
          if (hcnt_q != HMAX) hcnt_d = hcnt_q + 1'b1;
          hold_d = (hcnt_q == HMAX - HW'(1));
          if (state_q == PRESSED) begin
            level_d = 1'b1;
            if (!s2_q) begin
              dcnt_d  = DW'(1);
              state_d = RELEASE_WAIT;
            end
          end else if (s2_q) begin
            dcnt_d  = '0;
            state_d = PRESSED;
          end else if (dcnt_q >= DMAX) begin
            level_d   = 1'b0;
            release_d = 1'b1;
            dcnt_d    = '0;
            state_d   = RELEASED;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = RELEASED;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        state_q   <= RELEASED;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
      end else begin
        s1_q      <= bus.button_raw[i];
        s2_q      <= s1_q;
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        hold_q    <= hold_d;
      end
    end

    assign bus.btn_level[i]   = level_q;
    assign bus.btn_press[i]   = press_q;
    assign bus.btn_release[i] = release_q;
    assign bus.btn_hold[i]    = hold_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed stimulus for button_conditioner, checked every cycle
// against a run-length reference model of the debounce and hold rules.
module tb_button_conditioner;
  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_conditioner_if #(.NUM_BTN(NB)) bus ();

  button_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;

  logic [NB-1:0] raw_v = '0;
  logic          rst_v = 1'b1;

  // Reference state: synced-input pipeline, accepted level, length of the run
  // of synced samples disagreeing with the level, and cycles held since press.
  logic [NB-1:0] m_p1, m_p2, m_level, m_press, m_rel, m_hold;
  int m_run [NB];
  int m_held[NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    m_press = '0;
    m_rel   = '0;
    m_hold  = '0;
    if (rst_v) begin
      m_p1 = '0; m_p2 = '0; m_level = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (m_p2[i] != m_level[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_level[i] && m_held[i] < HOLD) begin
          m_held[i]++;
          if (m_held[i] == HOLD) m_hold[i] = 1'b1;
        end
        if (m_run[i] == DEB + 1) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          if (m_level[i]) begin
            m_press[i] = 1'b1;
            m_held[i]  = 0;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end
      m_p2 = m_p1;
      m_p1 = raw_v;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.button_raw = raw_v;
    rst = rst_v;
    @(posedge clk);
    #1;
    model_step();
    check("outs", {16'h0, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
          {16'h0, m_level, m_press, m_rel, m_hold});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int n;
  int seen_a, seen_b, seen_c;
  int left[NB];

  initial begin
    bus.button_raw = '0;
    rst = 1'b1;
    rst_v = 1'b1;
    raw_v = '0;
    ticks(3);
    check("reset_outs", {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold}, '0);
    rst_v = 1'b0;
    ticks(5);

    // 1: long press on channel 0
    raw_v[0] = 1'b1;
    tick();
    n = 0;
    while (!bus.btn_press[0] && n < 20) begin tick(); n++; end
    check("press0_latency", n, DEB + 2);
    check("level0_high", bus.btn_level[0], 1);
    n = 0;
    while (!bus.btn_hold[0] && n < 20) begin tick(); n++; end
    check("hold0_delay", n, HOLD);
    seen_a = 0;
    for (int k = 0; k < 8; k++) begin tick(); seen_a += bus.btn_hold[0]; end
    check("hold0_once", seen_a, 0);
    raw_v[0] = 1'b0;
    ticks(10);

    // 2: short bursts on channel 1 never qualify
    seen_a = 0;
    foreach (raw_v[j]) begin end
    for (int k = 0; k < 7; k++) begin
      raw_v[1] = (k != 2 && k != 6);
      tick();
      seen_a += bus.btn_press[1] + bus.btn_level[1];
    end
    raw_v[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); seen_a += bus.btn_press[1] + bus.btn_level[1]; end
    check("bounce1_no_press", seen_a, 0);

    // 3: brief dropout on a held channel 2
    raw_v[2] = 1'b1;
    ticks(8);
    check("level2_high", bus.btn_level[2], 1);
    raw_v[2] = 1'b0;
    ticks(2);
    raw_v[2] = 1'b1;
    seen_a = 0; seen_b = 0; seen_c = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      seen_a += bus.btn_release[2];
      seen_b += bus.btn_hold[2];
      seen_c += !bus.btn_level[2];
    end
    check("dropout2_no_release", seen_a, 0);
    check("dropout2_level", seen_c, 0);
    check("dropout2_hold", seen_b, 1);
    raw_v[2] = 1'b0;
    ticks(10);

    // 4: short press on channel 3, released before the hold time
    seen_a = 0; seen_b = 0; seen_c = 0;
    raw_v[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen_a += bus.btn_press[3]; seen_b += bus.btn_release[3]; seen_c += bus.btn_hold[3];
    end
    raw_v[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen_a += bus.btn_press[3]; seen_b += bus.btn_release[3]; seen_c += bus.btn_hold[3];
    end
    check("short3_presses", seen_a, 1);
    check("short3_releases", seen_b, 1);
    check("short3_no_hold", seen_c, 0);

    // 5: two channels rise together
    raw_v = 4'b0101;
    tick();
    n = 0;
    while (bus.btn_press == '0 && n < 20) begin tick(); n++; end
    check("simul_press", bus.btn_press, 4'b0101);
    raw_v = '0;
    ticks(12);

    // 6: reset while channel 1 is pressed
    raw_v[1] = 1'b1;
    ticks(8);
    check("level1_high", bus.btn_level[1], 1);
    rst_v = 1'b1;
    tick();
    check("rst_mid_outs", {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold}, '0);
    rst_v = 1'b0;
    n = 0;
    seen_a = 0;
    // one extra edge: the first edge after reset is the one capturing raw into s1
    while (!bus.btn_press[1] && n < 20) begin tick(); n++; seen_a += bus.btn_release[1]; end
    check("repress1_latency", n, DEB + 3);
    check("rst_no_release", seen_a, 0);
    raw_v = '0;
    ticks(10);

    // Random phase: per-channel random dwell lengths, occasional reset
    for (int i = 0; i < NB; i++) left[i] = $urandom_range(1, 14);
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++) begin
        left[i]--;
        if (left[i] <= 0) begin
          raw_v[i] = ~raw_v[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 24) : $urandom_range(1, 8);
        end
      end
      rst_v = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst_v = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
